pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, generalising the hand-written per-stage registers (D→E, E→M, M→W) into one block. Carries a generic payload plus the fields every stage needs:
- `valid` bit,
- PC,
- branch-delay flag,
- exception code,
- the T_new hazard countdown, with saturating decrement.

It supports bubble insertion, exception flush to the handler vector, and a freeze (hold) mode for multi-cycle downstream stalls. It has optional saturating bubble/flush performance counters.

## Interface
Parameters:
- PAYLOAD_W, 128, width of opaque payload (operands, rs/rt/rd, imm, instr, control)
- TNEW_W, 2, width of T_new countdown
- EXC_W, 5, width of exception code
- RESET_PC, 32'h0000_0000, out_pc after reset
- EXC_VECTOR, 32'h0000_4180, out_pc loaded on req_i
- BUBBLE_CLEAR, 1, 1: payload zeroed on bubble/flush; 0: payload left unchanged, only control fields cleared
- CNT_W, 32, perf counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_i  in  1  exception/interrupt flush
- hold_i  in  1  freeze stage contents
- stall_i  in  1  insert bubble (upstream stalled)
- in_valid  in  1  upstream instruction valid
- in_pc  in  32  upstream PC
- in_bd  in  1  upstream branch-delay flag
- in_tnew  in  TNEW_W  upstream T_new
- in_exc  in  EXC_W  upstream exception code
- in_payload  in  PAYLOAD_W  upstream payload
- out_valid, out_pc, out_bd, out_tnew, out_exc, out_payload  out  (matching widths)  registered stage contents
- bubble_cnt  out  CNT_W  bubbles inserted (0 unless PIPE_STAGE_PERF_EN)
- flush_cnt  out  CNT_W  req flushes (0 unless PIPE_STAGE_PERF_EN)

## Operation
Exactly one action is taken per cycle, in priority order:
1. **RESET** (reset=1):
   - out_valid=0, out_pc=RESET_PC, out_bd=0, out_tnew=0, out_exc=0, out_payload=0.
   - Counters cleared to 0.
2. **FLUSH** (req_i=1):
   - out_valid=0, out_pc=EXC_VECTOR, out_bd=0, out_tnew=0, out_exc=0.
   - Payload zeroed if BUBBLE_CLEAR=1, else unchanged.
   - flush_cnt increments.
   - FLUSH overrides hold_i and stall_i.
3. **HOLD** (hold_i=1):
   - Every output and counter keeps its value.
   - out_tnew does not decrement.
4. **BUBBLE** (stall_i=1):
   - out_valid=0, out_tnew=0, out_exc=0.
   - out_pc=in_pc and out_bd=in_bd, so the exception PC / BD are preserved for the stalled instruction.
   - Payload zeroed if BUBBLE_CLEAR=1, else unchanged.
   - bubble_cnt increments.
5. **LOAD** (otherwise):
   - All outputs take the corresponding inputs.
   - out_tnew = (in_tnew==0) ? 0 : in_tnew-1. This is a saturating decrement, never wraps.

Rules that apply across actions:
- in_valid=0 on LOAD is passed through as out_valid=0, but payload and other fields are still loaded, and no counter increments.
- Counters saturate at all-ones; they never wrap.
- The block is purely a register stage: there is no combinational path from any input to any output.

## Timing
- Latency: 1 cycle, input sampled at edge N, visible after edge N.
- reset, req_i, hold_i and stall_i all take effect at the next rising edge; none is asynchronous.
- Simultaneous events resolve strictly by the priority above. Examples:
  - req_i+stall_i → FLUSH, out_pc=EXC_VECTOR.
  - hold_i+stall_i → HOLD, no bubble counted.
- A reset asserted mid-hold or mid-stall sequence wins immediately. The first non-reset cycle follows the normal priority.
- Consecutive FLUSH cycles each reload EXC_VECTOR and each increment flush_cnt.

## Configuration
- **PIPE_STAGE_PERF_EN defined:**
  - bubble_cnt and flush_cnt are CNT_W-bit saturating registers behaving as above.
- **Not defined:**
  - Counters are not instantiated; bubble_cnt and flush_cnt are tied to constant 0.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold reset 2 cycles with random inputs → all outputs = reset values, out_pc=RESET_PC, counters=0.
- **LOAD / T_new:**
  - in_tnew=2, in_pc=32'h3004, in_valid=1 → next cycle out_tnew=1, out_pc=32'h3004, out_valid=1.
  - in_tnew=0 → out_tnew=0, no wrap to 3.
- **BUBBLE:** stall_i=1, in_pc=32'h3010, in_bd=1, in_exc=5'd10 → out_valid=0, out_pc=32'h3010, out_bd=1, out_exc=0, payload=0 with BUBBLE_CLEAR=1. With PIPE_STAGE_PERF_EN, bubble_cnt=1.
- **FLUSH priority:** req_i=1, stall_i=1, hold_i=1 together → out_pc=32'h4180, out_bd=0, out_valid=0, flush_cnt=1, bubble_cnt unchanged.
- **HOLD:** load out_pc=32'h3020 with out_tnew=1, then hold_i=1 for 3 cycles with changing inputs → outputs unchanged, out_tnew stays 1. Release → next cycle loads the current inputs.
- **Saturation / BUBBLE_CLEAR=0:**
  - CNT_W=2, 5 consecutive stalls → bubble_cnt=3.
  - BUBBLE_CLEAR=0, payload previously 128'hA5..A5, then stall → out_payload still 128'hA5..A5, out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/PC/BD/exception/T_new fields plus opaque payload,
// with flush-to-vector, freeze and bubble actions. Define PIPE_STAGE_PERF_EN for perf counters.
module pipe_stage_reg #(
   parameter int          PAYLOAD_W    = 128,
   parameter int          TNEW_W       = 2,
   parameter int          EXC_W        = 5,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
   parameter bit          BUBBLE_CLEAR = 1'b1,
   parameter int          CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_i,
   input  logic                 hold_i,
   input  logic                 stall_i,
   input  logic                 in_valid,
   input  logic [31:0]          in_pc,
   input  logic                 in_bd,
   input  logic [TNEW_W-1:0]    in_tnew,
   input  logic [EXC_W-1:0]     in_exc,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   output logic [31:0]          out_pc,
   output logic                 out_bd,
   output logic [TNEW_W-1:0]    out_tnew,
   output logic [EXC_W-1:0]     out_exc,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CNT_W-1:0]     bubble_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   // Valid semantics: out_valid marks a real instruction in this stage; there is no
   // ready back-pressure, downstream freezes the stage with hold_i instead.
   logic [TNEW_W-1:0] tnew_dec;

   assign tnew_dec = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_pc      <= RESET_PC;
         out_bd      <= 1'b0;
         out_tnew    <= '0;
         out_exc     <= '0;
         out_payload <= '0;
      end else if (req_i) begin
         out_valid <= 1'b0;
         out_pc    <= EXC_VECTOR;
         out_bd    <= 1'b0;
         out_tnew  <= '0;
         out_exc   <= '0;
         if (BUBBLE_CLEAR) out_payload <= '0;
      end else if (hold_i) begin
         out_valid <= out_valid;
      end else if (stall_i) begin
         // PC and BD follow the stalled instruction so a later exception reports it correctly.
         out_valid <= 1'b0;
         out_pc    <= in_pc;
         out_bd    <= in_bd;
         out_tnew  <= '0;
         out_exc   <= '0;
         if (BUBBLE_CLEAR) out_payload <= '0;
      end else begin
         out_valid   <= in_valid;
         out_pc      <= in_pc;
         out_bd      <= in_bd;
         out_tnew    <= tnew_dec;
         out_exc     <= in_exc;
         out_payload <= in_payload;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_q <= '0;
         flush_q  <= '0;
      end else if (req_i) begin
         if (flush_q != '1) flush_q <= flush_q + CNT_W'(1);
      end else if (!hold_i && stall_i) begin
         if (bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
      end
   end

   assign bubble_cnt = bubble_q;
   assign flush_cnt  = flush_q;
`else
   assign bubble_cnt = '0;
   assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default instance and a CNT_W=2 / BUBBLE_CLEAR=0 instance share
// stimulus and are compared against a priority-rule model with event counts.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic         valid;
      logic [31:0]  pc;
      logic         bd;
      logic [1:0]   tnew;
      logic [4:0]   exc;
      logic [127:0] payload;
   } st_t;

   logic clk = 1'b0;
   logic reset, req_i, hold_i, stall_i, in_valid, in_bd;
   logic [31:0] in_pc;
   logic [1:0] in_tnew;
   logic [4:0] in_exc;
   logic [127:0] in_payload;

   logic out_valid0, out_bd0, out_valid1, out_bd1;
   logic [31:0] out_pc0, out_pc1;
   logic [1:0] out_tnew0, out_tnew1;
   logic [4:0] out_exc0, out_exc1;
   logic [127:0] out_payload0, out_payload1;
   logic [31:0] bubble_cnt0, flush_cnt0;
   logic [1:0] bubble_cnt1, flush_cnt1;

   st_t m0, m1;
   longint n_bub, n_fl;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut0 (
      .clk(clk), .reset(reset), .req_i(req_i), .hold_i(hold_i), .stall_i(stall_i),
      .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_tnew(in_tnew), .in_exc(in_exc),
      .in_payload(in_payload), .out_valid(out_valid0), .out_pc(out_pc0), .out_bd(out_bd0),
      .out_tnew(out_tnew0), .out_exc(out_exc0), .out_payload(out_payload0),
      .bubble_cnt(bubble_cnt0), .flush_cnt(flush_cnt0)
   );

   pipe_stage_reg #(.CNT_W(2), .BUBBLE_CLEAR(1'b0)) dut1 (
      .clk(clk), .reset(reset), .req_i(req_i), .hold_i(hold_i), .stall_i(stall_i),
      .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_tnew(in_tnew), .in_exc(in_exc),
      .in_payload(in_payload), .out_valid(out_valid1), .out_pc(out_pc1), .out_bd(out_bd1),
      .out_tnew(out_tnew1), .out_exc(out_exc1), .out_payload(out_payload1),
      .bubble_cnt(bubble_cnt1), .flush_cnt(flush_cnt1)
   );

   // Reference: one action per cycle chosen by priority.
   function automatic st_t next_st(st_t cur, bit clr);
      st_t n = cur;
      if (reset) begin
         n.valid = 0; n.pc = 32'h0; n.bd = 0; n.tnew = 0; n.exc = 0; n.payload = '0;
      end else if (req_i) begin
         n.valid = 0; n.pc = 32'h4180; n.bd = 0; n.tnew = 0; n.exc = 0;
         if (clr) n.payload = '0;
      end else if (hold_i) begin
         n = cur;
      end else if (stall_i) begin
         n.valid = 0; n.pc = in_pc; n.bd = in_bd; n.tnew = 0; n.exc = 0;
         if (clr) n.payload = '0;
      end else begin
         n.valid = in_valid; n.pc = in_pc; n.bd = in_bd; n.exc = in_exc; n.payload = in_payload;
         n.tnew = (int'(in_tnew) > 0) ? 2'(int'(in_tnew) - 1) : 2'd0;
      end
      return n;
   endfunction

   function automatic logic [31:0] exp32(longint n);
      if (!PERF) return 32'h0;
      return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(n);
   endfunction

   function automatic logic [1:0] exp2(longint n);
      if (!PERF) return 2'd0;
      return (n > 3) ? 2'd3 : 2'(n);
   endfunction

   task automatic tick();
      @(posedge clk);
      m0 = next_st(m0, 1'b1);
      m1 = next_st(m1, 1'b0);
      if (reset) begin n_bub = 0; n_fl = 0; end
      else if (req_i) n_fl++;
      else if (!hold_i && stall_i) n_bub++;
      @(negedge clk);
   endtask

   task automatic drive_idle();
      reset = 0; req_i = 0; hold_i = 0; stall_i = 0;
   endtask

   task automatic drive_random_data();
      in_valid = 1'($urandom); in_pc = $urandom; in_bd = 1'($urandom);
      in_tnew = 2'($urandom_range(0, 3)); in_exc = 5'($urandom_range(0, 31));
      in_payload = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic test_reset();
      drive_random_data(); drive_idle(); reset = 1; req_i = 1'($urandom); stall_i = 1'($urandom);
      tick(); drive_random_data(); tick();
      n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid0); end
      n_checks++; if (out_pc0 !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp 00000000", out_pc0); end
      n_checks++; if ({out_bd0, out_tnew0, out_exc0} !== 8'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 00", {out_bd0, out_tnew0, out_exc0}); end
      n_checks++; if (out_payload0 !== 128'h0 || out_payload1 !== 128'h0) begin n_fail++; $display("FAIL reset_payload: got %h / %h exp 0", out_payload0, out_payload1); end
      n_checks++; if ({bubble_cnt0, flush_cnt0, bubble_cnt1, flush_cnt1} !== 68'h0) begin n_fail++; $display("FAIL reset_cnt: got %h %h %h %h exp 0", bubble_cnt0, flush_cnt0, bubble_cnt1, flush_cnt1); end
      reset = 0;
   endtask

   task automatic test_load_tnew();
      drive_idle(); drive_random_data();
      in_tnew = 2'd2; in_pc = 32'h3004; in_valid = 1;
      tick();
      n_checks++; if (out_tnew0 !== 2'd1) begin n_fail++; $display("FAIL load_tnew: got %0d exp 1", out_tnew0); end
      n_checks++; if (out_pc0 !== 32'h3004) begin n_fail++; $display("FAIL load_pc: got %h exp 00003004", out_pc0); end
      n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b exp 1", out_valid0); end
      n_checks++; if (out_payload0 !== in_payload || out_exc0 !== in_exc) begin n_fail++; $display("FAIL load_payload: got %h exp %h", out_payload0, in_payload); end
      in_tnew = 2'd0; in_valid = 0;
      tick();
      n_checks++; if (out_tnew0 !== 2'd0) begin n_fail++; $display("FAIL load_tnew_sat: got %0d exp 0", out_tnew0); end
      n_checks++; if (out_valid0 !== 1'b0 || out_payload0 !== in_payload) begin n_fail++; $display("FAIL load_invalid: got %b %h exp 0 %h", out_valid0, out_payload0, in_payload); end
   endtask

   task automatic test_bubble();
      drive_idle(); drive_random_data();
      in_payload = {4{32'hA5A5_A5A5}}; in_valid = 1;
      tick();
      stall_i = 1; in_pc = 32'h3010; in_bd = 1; in_exc = 5'd10; in_payload = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b %b exp 0", out_valid0, out_valid1); end
      n_checks++; if (out_pc0 !== 32'h3010 || out_bd0 !== 1'b1) begin n_fail++; $display("FAIL bubble_pc_bd: got %h %b exp 00003010 1", out_pc0, out_bd0); end
      n_checks++; if (out_exc0 !== 5'd0 || out_tnew0 !== 2'd0) begin n_fail++; $display("FAIL bubble_exc: got %0d %0d exp 0 0", out_exc0, out_tnew0); end
      n_checks++; if (out_payload0 !== 128'h0) begin n_fail++; $display("FAIL bubble_clear1: got %h exp 0", out_payload0); end
      n_checks++; if (out_payload1 !== {4{32'hA5A5_A5A5}}) begin n_fail++; $display("FAIL bubble_clear0: got %h exp a5..a5", out_payload1); end
      n_checks++; if (bubble_cnt0 !== exp32(n_bub)) begin n_fail++; $display("FAIL bubble_cnt: got %0d exp %0d", bubble_cnt0, exp32(n_bub)); end
      stall_i = 0;
   endtask

   task automatic test_flush_priority();
      drive_idle(); drive_random_data(); in_bd = 1;
      tick();
      req_i = 1; stall_i = 1; hold_i = 1;
      tick();
      n_checks++; if (out_pc0 !== 32'h4180 || out_pc1 !== 32'h4180) begin n_fail++; $display("FAIL flush_pc: got %h %h exp 00004180", out_pc0, out_pc1); end
      n_checks++; if (out_bd0 !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++; $display("FAIL flush_ctrl: got %b %b exp 0 0", out_bd0, out_valid0); end
      n_checks++; if (flush_cnt0 !== exp32(n_fl) || flush_cnt1 !== exp2(n_fl)) begin n_fail++; $display("FAIL flush_cnt: got %0d %0d exp %0d", flush_cnt0, flush_cnt1, exp32(n_fl)); end
      n_checks++; if (bubble_cnt0 !== exp32(n_bub)) begin n_fail++; $display("FAIL flush_bubble_cnt: got %0d exp %0d", bubble_cnt0, exp32(n_bub)); end
      n_checks++; if (out_payload1 !== m1.payload) begin n_fail++; $display("FAIL flush_clear0: got %h exp %h", out_payload1, m1.payload); end
      hold_i = 0; stall_i = 0; drive_random_data(); in_pc = 32'h1234;
      tick();
      n_checks++; if (out_pc0 !== 32'h4180 || flush_cnt0 !== exp32(n_fl)) begin n_fail++; $display("FAIL flush_b2b: got %h %0d exp 00004180 %0d", out_pc0, flush_cnt0, exp32(n_fl)); end
      req_i = 0;
   endtask

   task automatic test_hold();
      drive_idle(); drive_random_data();
      in_pc = 32'h3020; in_tnew = 2'd2; in_valid = 1;
      tick();
      hold_i = 1;
      for (int i = 0; i < 3; i++) begin
         drive_random_data(); stall_i = 1'($urandom);
         tick();
         n_checks++; if (out_pc0 !== 32'h3020 || out_tnew0 !== 2'd1 || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL hold_%0d: got %h %0d %b exp 00003020 1 1", i, out_pc0, out_tnew0, out_valid0); end
      end
      n_checks++; if (bubble_cnt0 !== exp32(n_bub)) begin n_fail++; $display("FAIL hold_bubble_cnt: got %0d exp %0d", bubble_cnt0, exp32(n_bub)); end
      drive_idle(); drive_random_data();
      tick();
      n_checks++; if (out_pc0 !== in_pc || out_payload0 !== in_payload) begin n_fail++; $display("FAIL hold_release: got %h exp %h", out_pc0, in_pc); end
      hold_i = 1; tick(); reset = 1;
      tick();
      n_checks++; if (out_pc0 !== 32'h0 || out_valid0 !== 1'b0 || flush_cnt0 !== 32'h0) begin n_fail++; $display("FAIL reset_mid_hold: got %h %b %0d exp 0 0 0", out_pc0, out_valid0, flush_cnt0); end
      drive_idle();
   endtask

   task automatic test_saturation();
      drive_idle(); reset = 1; tick(); reset = 0;
      for (int i = 0; i < 5; i++) begin
         drive_random_data(); stall_i = 1;
         tick();
      end
      n_checks++; if (bubble_cnt1 !== (PERF ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL sat_bubble2: got %0d exp %0d", bubble_cnt1, PERF ? 3 : 0); end
      n_checks++; if (bubble_cnt0 !== (PERF ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL sat_bubble32: got %0d exp %0d", bubble_cnt0, PERF ? 5 : 0); end
      for (int i = 0; i < 5; i++) begin
         stall_i = 0; req_i = 1;
         tick();
      end
      n_checks++; if (flush_cnt1 !== (PERF ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL sat_flush2: got %0d exp %0d", flush_cnt1, PERF ? 3 : 0); end
      drive_idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_random_data();
         reset   = ($urandom_range(0, 39) == 0);
         req_i   = ($urandom_range(0, 9) == 0);
         hold_i  = ($urandom_range(0, 4) == 0);
         stall_i = ($urandom_range(0, 4) == 0);
         tick();
         n_checks++; if ({out_valid0, out_pc0, out_bd0, out_tnew0, out_exc0, out_payload0} !== {m0.valid, m0.pc, m0.bd, m0.tnew, m0.exc, m0.payload}) begin
            n_fail++; $display("FAIL rand_dut0 cyc %0d: got %b %h %b %0d %0d %h exp %b %h %b %0d %0d %h", i, out_valid0, out_pc0, out_bd0, out_tnew0, out_exc0, out_payload0, m0.valid, m0.pc, m0.bd, m0.tnew, m0.exc, m0.payload); end
         n_checks++; if ({out_valid1, out_pc1, out_bd1, out_tnew1, out_exc1, out_payload1} !== {m1.valid, m1.pc, m1.bd, m1.tnew, m1.exc, m1.payload}) begin
            n_fail++; $display("FAIL rand_dut1 cyc %0d: got %b %h %b %0d %0d %h exp %b %h %b %0d %0d %h", i, out_valid1, out_pc1, out_bd1, out_tnew1, out_exc1, out_payload1, m1.valid, m1.pc, m1.bd, m1.tnew, m1.exc, m1.payload); end
         n_checks++; if ({bubble_cnt0, flush_cnt0, bubble_cnt1, flush_cnt1} !== {exp32(n_bub), exp32(n_fl), exp2(n_bub), exp2(n_fl)}) begin
            n_fail++; $display("FAIL rand_cnt cyc %0d: got %0d %0d %0d %0d exp %0d %0d %0d %0d", i, bubble_cnt0, flush_cnt0, bubble_cnt1, flush_cnt1, exp32(n_bub), exp32(n_fl), exp2(n_bub), exp2(n_fl)); end
      end
      drive_idle();
   endtask

   initial begin
      m0 = '{valid: 0, pc: 0, bd: 0, tnew: 0, exc: 0, payload: '0};
      m1 = m0; n_bub = 0; n_fl = 0;
      drive_idle(); drive_random_data(); reset = 1;
      @(negedge clk);
      test_reset();
      test_load_tnew();
      test_bubble();
      test_flush_priority();
      test_hold();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
